// File: rtl/sound_arbiter_if.sv
// Buzzer arbiter bus: game/menu event pulses and mute in, buzzer drive and status out.
interface sound_arbiter_if;
   logic       enable;
   logic       req_point;
   logic       req_paddle;
   logic       req_wall;
   logic       req_menu;
   logic       buzzer;
   logic       busy;
   logic [2:0] playing_id;

   modport master (
      output enable, req_point, req_paddle, req_wall, req_menu,
      input  buzzer, busy, playing_id
   );

   modport slave (
      input  enable, req_point, req_paddle, req_wall, req_menu,
      output buzzer, busy, playing_id
   );
endinterface

// File: rtl/sound_arbiter.sv
// Fixed-priority buzzer arbiter (point > paddle > wall > menu); buzzer rises on the edge sampling a request.
// Requests are latched while busy and never stall the sender; repeats of the playing source are coalesced.
module sound_arbiter #(
   parameter int unsigned MS_DIV       = 12000,
   parameter int unsigned PADDLE_HALF  = 6000,
   parameter int unsigned WALL_HALF    = 12000,
   parameter int unsigned MENU_HALF    = 3000,
   parameter int unsigned POINT_HALF_A = 4000,
   parameter int unsigned POINT_HALF_B = 8000,
   parameter int unsigned BEEP_MS      = 40,
   parameter int unsigned POINT_MS     = 120,
   parameter int unsigned GAP_MS       = 20
) (
   input logic            clk,
   input logic            reset,
   sound_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, TONE, GAP, TONE2} state_t;

   state_t      state;
   logic [3:0]  pending;
   logic [15:0] half_cnt;
   logic [15:0] half_rld;
   logic [15:0] pre_cnt;
   logic [7:0]  dur_cnt;
   logic        buzzer_q;
   logic        busy_q;
   logic [2:0]  id_q;

   logic [3:0]  req;
   logic [3:0]  cand;
   logic [3:0]  grant;
   logic [3:0]  play_mask;
   logic [2:0]  win_id;
   logic [15:0] win_half;
   logic [7:0]  win_ms;
   logic        ms_wrap;
   logic        phase_end;

   always_comb begin
      req      = {bus.req_menu, bus.req_wall, bus.req_paddle, bus.req_point};
      cand     = pending | req;
      grant    = 4'b0000;
      win_id   = 3'd0;
      win_half = 16'd0;
      win_ms   = 8'd0;
      if (cand[0]) begin
         grant    = 4'b0001;
         win_id   = 3'd1;
         win_half = 16'(POINT_HALF_A - 1);
         win_ms   = 8'(POINT_MS);
      end else if (cand[1]) begin
         grant    = 4'b0010;
         win_id   = 3'd2;
         win_half = 16'(PADDLE_HALF - 1);
         win_ms   = 8'(BEEP_MS);
      end else if (cand[2]) begin
         grant    = 4'b0100;
         win_id   = 3'd3;
         win_half = 16'(WALL_HALF - 1);
         win_ms   = 8'(BEEP_MS);
      end else if (cand[3]) begin
         grant    = 4'b1000;
         win_id   = 3'd4;
         win_half = 16'(MENU_HALF - 1);
         win_ms   = 8'(BEEP_MS);
      end
   end

   always_comb begin
      play_mask = 4'b0000;
      case (id_q)
         3'd1:    play_mask = 4'b0001;
         3'd2:    play_mask = 4'b0010;
         3'd3:    play_mask = 4'b0100;
         3'd4:    play_mask = 4'b1000;
         default: play_mask = 4'b0000;
      endcase
   end

   assign ms_wrap   = (pre_cnt == 16'(MS_DIV - 1));
   assign phase_end = ms_wrap && (dur_cnt == 8'd1);

   always_ff @(posedge clk) begin
      if (reset || !bus.enable) begin
         state    <= IDLE;
         pending  <= 4'b0000;
         half_cnt <= 16'd0;
         half_rld <= 16'd0;
         pre_cnt  <= 16'd0;
         dur_cnt  <= 8'd0;
         buzzer_q <= 1'b0;
         busy_q   <= 1'b0;
         id_q     <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|cand) begin
                  pending  <= cand & ~grant;
                  half_cnt <= win_half;
                  half_rld <= win_half;
                  pre_cnt  <= 16'd0;
                  dur_cnt  <= win_ms;
                  buzzer_q <= 1'b1;
                  busy_q   <= 1'b1;
                  id_q     <= win_id;
                  state    <= TONE;
               end
            end
            default: begin
               pending <= pending | (req & ~play_mask);
               pre_cnt <= ms_wrap ? 16'd0 : pre_cnt + 16'd1;
               if (ms_wrap) begin
                  dur_cnt <= dur_cnt - 8'd1;
               end
               if (state != GAP) begin
                  if (half_cnt == 16'd0) begin
                     half_cnt <= half_rld;
                     buzzer_q <= ~buzzer_q;
                  end else begin
                     half_cnt <= half_cnt - 16'd1;
                  end
               end
               // Phase end overrides the tone toggle and counter updates above.
               if (phase_end) begin
                  pre_cnt <= 16'd0;
                  if (state == TONE && id_q == 3'd1) begin
                     state    <= GAP;
                     buzzer_q <= 1'b0;
                     dur_cnt  <= 8'(GAP_MS);
                  end else if (state == GAP) begin
                     state    <= TONE2;
                     buzzer_q <= 1'b1;
                     half_cnt <= 16'(POINT_HALF_B - 1);
                     half_rld <= 16'(POINT_HALF_B - 1);
                     dur_cnt  <= 8'(POINT_MS);
                  end else begin
                     state    <= IDLE;
                     buzzer_q <= 1'b0;
                     busy_q   <= 1'b0;
                     id_q     <= 3'd0;
                     half_cnt <= 16'd0;
                     half_rld <= 16'd0;
                     dur_cnt  <= 8'd0;
                  end
               end
            end
         endcase
      end
   end

   assign bus.buzzer     = buzzer_q;
   assign bus.busy       = busy_q;
   assign bus.playing_id = id_q;
endmodule
